csa_mantissa_multiplier: RTL and testbench
==========================================

// Module: csa_mantissa_multiplier
// PURPOSE
//  Iterative unsigned mantissa multiplier. It produces the carry-save pair (s9_final, c9_final) that
//  CLA_module consumes. Each cycle it folds BITS_PER_CYCLE partial products of mant_a*mant_b into
//  48-bit sum/carry registers through a chain of 3:2 compressors. It sits between operand unpack
//  and the CLA final adder, with valid/ready on both sides.
// PARAMETERS
//  MANT_W          24  mantissa width incl. hidden bit; product width PROD_W = 2*MANT_W (localparam)
//  BITS_PER_CYCLE   4  multiplier bits consumed per BUSY cycle; must divide MANT_W (elaboration error otherwise)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  nreset      in   1       synchronous active-low reset
//  in_valid    in   1       operand pair valid
//  in_ready    out  1       block can accept operands (high only in IDLE)
//  mant_a      in   MANT_W  multiplicand
//  mant_b      in   MANT_W  multiplier
//  out_valid   out  1       s9_final/c9_final hold a finished carry-save product
//  out_ready   in   1       downstream (CLA stage) accepts result
//  s9_final    out  PROD_W  carry-save sum vector
//  c9_final    out  PROD_W  carry-save carry vector
//  busy        out  1       high in BUSY and DONE
// BEHAVIOUR
//  Reset (nreset=0 at edge): state=IDLE; s9_final=c9_final=0; out_valid=0; busy=0; in_ready=1 after the edge.
//   Reset wins over every other event, including mid-BUSY and DONE; an in-flight op is dropped silently.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid at an edge, capture a, b; clear s, c; cnt=0.
//     If a==0 or b==0: go straight to DONE with s=c=0, so out_valid is high the cycle after acceptance.
//     Otherwise go to BUSY.
//   BUSY: each edge, for j=0..BITS_PER_CYCLE-1, set k=cnt*BITS_PER_CYCLE+j.
//     If b[k]=1: {s,c} = CSA(s, c, a<<k). CSA sum = s^c^pp; CSA carry = maj(s,c,pp)<<1, truncated to PROD_W.
//     Compressors are chained combinationally within the cycle; cnt increments once per edge.
//     The edge that processes the last chunk (cnt = MANT_W/BITS_PER_CYCLE-1) moves to DONE.
//     With the default 24/4: 6 BUSY edges; out_valid rises 6 cycles after the acceptance edge.
//     in_valid is ignored (in_ready=0).
//   DONE: out_valid=1; s9_final/c9_final held stable while out_ready=0 (indefinite backpressure allowed).
//     On an edge with out_ready=1, go to IDLE and drop out_valid. No accept in that same cycle
//     (one-cycle bubble; throughput 1 op per 8 cycles with defaults).
//  Arithmetic contract: (s9_final + c9_final) mod 2^PROD_W == mant_a*mant_b exactly.
//   The product always fits in PROD_W bits.
//   The carry_out of the downstream adder is NOT part of the contract and may be 1; consumers must ignore it.
//  Outputs are registered; s9_final/c9_final show the live accumulators in BUSY and are only meaningful while out_valid=1.
//  Operand capture is registered; changes on mant_a/mant_b after acceptance have no effect.
// TESTING
//  1 a=24'hFFFFFF, b=24'hFFFFFF -> out_valid 6 cycles after accept; s+c mod 2^48 = 48'hFFFFFE000001.
//  2 a=24'h800000, b=24'h800000 -> s+c mod 2^48 = 48'h400000000000; a=24'h000001, b=24'hABCDEF -> 48'h000000ABCDEF.
//  3 a=0, b=24'h123456 -> out_valid the cycle after accept; s9_final=c9_final=0; never enters BUSY.
//  4 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second capture;
//    out_ready=1 -> IDLE next cycle, then accept.
//  5 nreset=0 on the 3rd BUSY cycle -> next cycle IDLE, outputs 0, out_valid=0, in_ready=1; new op then completes correctly.
//  6 Chain to CLA_module; 1000 random (a,b) with random out_ready stalls -> mantissa_mul == a*b every time, no lost or duplicated results.

Source files
------------

// File: rtl/csa_mantissa_multiplier_if.sv
// Operand/result handshake bundle for the carry-save mantissa multiplier.
// Ports: in_valid/in_ready/mant_a/mant_b on the operand side;
//        out_valid/out_ready/s9_final/c9_final on the result side, plus busy.
interface csa_mantissa_multiplier_if #(
  parameter int MANT_W = 24
);
  localparam int PROD_W = 2 * MANT_W;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] s9_final;
  logic [PROD_W-1:0] c9_final;
  logic              busy;

  // master: operand producer / result consumer
  modport master (
    output in_valid, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, s9_final, c9_final, busy
  );

  // slave: the multiplier itself
  modport slave (
    input  in_valid, mant_a, mant_b, out_ready,
    output in_ready, out_valid, s9_final, c9_final, busy
  );
endinterface

// File: rtl/csa_mantissa_multiplier.sv
// Iterative unsigned mantissa multiplier producing a carry-save product pair (s9_final, c9_final).
// Latency: MANT_W/BITS_PER_CYCLE cycles after accept (zero operand: next cycle); 1 op per N+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE, one bubble after DONE.
// Ports: clk, nreset (sync, active-low), bus (slave modport of csa_mantissa_multiplier_if).
module csa_mantissa_multiplier #(
  parameter int MANT_W         = 24,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  csa_mantissa_multiplier_if.slave   bus
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int NCHUNK = MANT_W / BITS_PER_CYCLE;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (BITS_PER_CYCLE < 1 || (MANT_W % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("csa_mantissa_multiplier: BITS_PER_CYCLE must divide MANT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] a_sh_q;   // multiplicand pre-shifted to the current chunk's weight
  logic [MANT_W-1:0] b_q;      // multiplier shifted down so bit 0 is the current chunk's LSB
  logic [PROD_W-1:0] s_q;
  logic [PROD_W-1:0] c_q;

  logic [PROD_W-1:0] s_acc;
  logic [PROD_W-1:0] c_acc;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] t_sum;
  logic [PROD_W-1:0] t_carry;

  logic              last_chunk;
  logic              zero_op;

  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
  assign zero_op    = (bus.mant_a == '0) || (bus.mant_b == '0);

  // Chain of 3:2 compressors: each set multiplier bit folds one partial product
  // into the running carry-save pair within the same cycle.
  always_comb begin
    s_acc   = s_q;
    c_acc   = c_q;
    pp      = '0;
    t_sum   = '0;
    t_carry = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) begin
        pp      = a_sh_q << j;
        t_sum   = s_acc ^ c_acc ^ pp;
        t_carry = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
        s_acc   = t_sum;
        c_acc   = t_carry;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_nxt = zero_op ? DONE : BUSY;
      BUSY: if (last_chunk)   state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q <= {{MANT_W{1'b0}}, bus.mant_a};
            b_q    <= bus.mant_b;
            s_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          s_q    <= s_acc;
          c_q    <= c_acc;
          a_sh_q <= a_sh_q << BITS_PER_CYCLE;
          b_q    <= b_q >> BITS_PER_CYCLE;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s9_final  = s_q;
  assign bus.c9_final  = c_q;

endmodule

// File: tb/tb_csa_mantissa_multiplier.sv
// Directed bench for csa_mantissa_multiplier: reset, corner products, zero bypass,
// DONE backpressure, reset mid-operation and a back-to-back sequence with stalls.
module tb_csa_mantissa_multiplier;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  csa_mantissa_multiplier_if #(.MANT_W(24)) bus ();

  csa_mantissa_multiplier #(
    .MANT_W(24),
    .BITS_PER_CYCLE(4)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus.slave)
  );

  function automatic logic [47:0] cs_sum();
    logic [47:0] r;
    r = bus.s9_final + bus.c9_final;
    return r;
  endfunction

  // Caller sits at a negedge in IDLE. Presents operands for one edge, then counts
  // edges after the accept edge until out_valid is seen (bounded).
  task automatic start_op(input logic [23:0] a, input logic [23:0] b, output int lat);
    bus.in_valid = 1'b1;
    bus.mant_a   = a;
    bus.mant_b   = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mant_a   = 24'h5A5A5A;
    bus.mant_b   = 24'hA5A5A5;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.mant_a    = 24'h111111;
    bus.mant_b    = 24'h222222;
    bus.out_ready = 1'b0;
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.s9_final !== 48'h0) begin failures++; $display("FAIL reset_s got=%h exp=0", bus.s9_final); end
    checks++; if (bus.c9_final !== 48'h0) begin failures++; $display("FAIL reset_c got=%h exp=0", bus.c9_final); end
    bus.in_valid = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_full_ones();
    int lat;
    start_op(24'hFFFFFF, 24'hFFFFFF, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL ones_latency got=%0d exp=6", lat); end
    checks++; if (cs_sum() !== 48'hFFFFFE000001) begin failures++; $display("FAIL ones_product got=%h exp=fffffe000001", cs_sum()); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL ones_done_flags got in_ready=%b busy=%b exp in_ready=0 busy=1", bus.in_ready, bus.busy); end
    finish_op();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL ones_release got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_corners();
    int lat;
    start_op(24'h800000, 24'h800000, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL msb_latency got=%0d exp=6", lat); end
    checks++; if (cs_sum() !== 48'h400000000000) begin failures++; $display("FAIL msb_product got=%h exp=400000000000", cs_sum()); end
    finish_op();
    start_op(24'h000001, 24'hABCDEF, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL one_latency got=%0d exp=6", lat); end
    checks++; if (cs_sum() !== 48'h000000ABCDEF) begin failures++; $display("FAIL one_product got=%h exp=000000abcdef", cs_sum()); end
    finish_op();
    start_op(24'h000123, 24'h000456, lat);
    checks++; if (cs_sum() !== 48'h00000004EDC2) begin failures++; $display("FAIL small_product got=%h exp=00000004edc2", cs_sum()); end
    finish_op();
  endtask

  task automatic test_zero();
    int lat;
    start_op(24'h000000, 24'h123456, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL zero_a_latency got=%0d exp=0", lat); end
    checks++; if (bus.s9_final !== 48'h0 || bus.c9_final !== 48'h0) begin failures++; $display("FAIL zero_a_vectors got s=%h c=%h exp 0/0", bus.s9_final, bus.c9_final); end
    finish_op();
    start_op(24'h654321, 24'h000000, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL zero_b_latency got=%0d exp=0", lat); end
    checks++; if (bus.s9_final !== 48'h0 || bus.c9_final !== 48'h0) begin failures++; $display("FAIL zero_b_vectors got s=%h c=%h exp 0/0", bus.s9_final, bus.c9_final); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [47:0] s0, c0;
    start_op(24'h000010, 24'h000100, lat);
    checks++; if (cs_sum() !== 48'h000000001000) begin failures++; $display("FAIL bp_product got=%h exp=000000001000", cs_sum()); end
    s0 = bus.s9_final;
    c0 = bus.c9_final;
    bus.in_valid = 1'b1;
    bus.mant_a   = 24'h000007;
    bus.mant_b   = 24'h000009;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.s9_final !== s0 || bus.c9_final !== c0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got s=%h c=%h ov=%b ir=%b exp s=%h c=%h ov=1 ir=0",
                 i, bus.s9_final, bus.c9_final, bus.out_valid, bus.in_ready, s0, c0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL bp_bubble got ov=%b ir=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_accept got busy=%b exp=1", bus.busy); end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 6) begin failures++; $display("FAIL bp_next_latency got=%0d exp=6", lat); end
    checks++; if (cs_sum() !== 48'h00000000003F) begin failures++; $display("FAIL bp_next_product got=%h exp=00000000003f", cs_sum()); end
    finish_op();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bus.in_valid = 1'b1;
    bus.mant_a   = 24'hFFFFFF;
    bus.mant_b   = 24'hFFFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_flags got ir=%b ov=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
    checks++; if (bus.s9_final !== 48'h0 || bus.c9_final !== 48'h0) begin failures++; $display("FAIL midrst_vectors got s=%h c=%h exp 0/0", bus.s9_final, bus.c9_final); end
    start_op(24'h000123, 24'h000456, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=6", lat); end
    checks++; if (cs_sum() !== 48'h00000004EDC2) begin failures++; $display("FAIL midrst_next_product got=%h exp=00000004edc2", cs_sum()); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [23:0] va [8];
    logic [23:0] vb [8];
    logic [47:0] exp_p;
    int lat;
    int results;
    va = '{24'hFFFFFF, 24'h123456, 24'h800001, 24'hC00000, 24'h000003, 24'hABCDEF, 24'h7FFFFF, 24'hFFFFFF};
    vb = '{24'h000002, 24'h654321, 24'h800001, 24'h000004, 24'h000005, 24'hFEDCBA, 24'h7FFFFF, 24'h000001};
    results = 0;
    for (int i = 0; i < 8; i++) begin
      exp_p = {24'h0, va[i]} * {24'h0, vb[i]};
      start_op(va[i], vb[i], lat);
      checks++; if (lat !== 6) begin failures++; $display("FAIL b2b_latency idx=%0d got=%0d exp=6", i, lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (cs_sum() !== exp_p) begin failures++; $display("FAIL b2b_product idx=%0d got=%h exp=%h", i, cs_sum(), exp_p); end
      if (bus.out_valid === 1'b1) results++;
      finish_op();
    end
    checks++; if (results !== 8) begin failures++; $display("FAIL b2b_result_count got=%0d exp=8", results); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got out_valid=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mant_a    = '0;
    bus.mant_b    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_ones();
    test_corners();
    test_zero();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
